// File: rtl/rr_8_to_3_encoder.sv
// Round-robin request encoder: latches per-register request lines into a pending
// set and streams their 3-bit indices over a valid/ready handshake with fair rotation.
module rr_8_to_3_encoder #(
    parameter logic [2:0] RESET_PTR = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_addr,
    output logic [7:0] pending,
    output logic [3:0] pending_cnt,
    output logic       merged
);

    logic [7:0] pending_q, pending_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [2:0] addr_q, addr_d;
    logic       merged_q, merged_d;
    logic [2:0] ptr_q, ptr_d;

    logic [2:0] sel;
    logic       found;
    logic [2:0] idx;
    logic       has_sel;
    logic       slot_free;
    logic       load;
    logic [7:0] clr;

    // First set pending bit at or after ptr_q, wrapping modulo 8.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign has_sel   = |pending_q;
    assign slot_free = !valid_q || out_ready;
    assign load      = slot_free && has_sel;

    always_comb begin
        clr       = '0;
        valid_d   = valid_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        if (load) begin
            clr[sel] = 1'b1;
            valid_d  = 1'b1;
            addr_d   = sel;
            ptr_d    = sel + 3'd1;
        end else if (valid_q && out_ready) begin
            valid_d  = 1'b0;
        end
        // A request on the bit being cleared re-sets it: set wins.
        pending_d = (pending_q & ~clr) | req;
        merged_d  = |(req & pending_q & ~clr);
        cnt_d     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt_d = cnt_d + 4'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            merged_q  <= 1'b0;
            ptr_q     <= RESET_PTR;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            merged_q  <= merged_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_addr    = addr_q;
    assign pending     = pending_q;
    assign pending_cnt = cnt_q;
    assign merged      = merged_q;

endmodule

// File: tb/tb_rr_8_to_3_encoder.sv
// Directed-vector bench for rr_8_to_3_encoder with hand-computed expectations.
module tb_rr_8_to_3_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_addr;
    logic [7:0] pending;
    logic [3:0] pending_cnt;
    logic       merged;

    int unsigned n_cmp;
    int unsigned n_bad;

    rr_8_to_3_encoder #(.RESET_PTR(3'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .pending    (pending),
        .pending_cnt(pending_cnt),
        .merged     (merged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".valid"},  32'(out_valid),   32'd0);
        check_eq({tag, ".pend"},   32'(pending),     32'h00);
        check_eq({tag, ".cnt"},    32'(pending_cnt), 32'd0);
        check_eq({tag, ".merged"}, 32'(merged),      32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        req       = '0;
        out_ready = 1'b0;

        // 1: reset state, then idle cycles
        #1 reset = 1'b1;
        #1;
        check_idle("rst");
        check_eq("rst.addr", 32'(out_addr), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("idle");
        end

        // 2: single request on bit 5
        out_ready = 1'b1;
        req = 8'h20;
        step();
        check_eq("s2.pend",  32'(pending),     32'h20);
        check_eq("s2.cnt",   32'(pending_cnt), 32'd1);
        check_eq("s2.valid0", 32'(out_valid),  32'd0);
        req = 8'h00;
        step();
        check_eq("s2.valid", 32'(out_valid),   32'd1);
        check_eq("s2.addr",  32'(out_addr),    32'd5);
        check_eq("s2.pend1", 32'(pending),     32'h00);
        step();
        check_eq("s2.drop",  32'(out_valid),   32'd0);

        // 3: full sweep starting at ptr=6
        req = 8'hFF;
        step();
        check_eq("s3.cnt8", 32'(pending_cnt), 32'd8);
        check_eq("s3.v0",   32'(out_valid),   32'd0);
        req = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("s3.valid", 32'(out_valid),   32'd1);
            check_eq("s3.addr",  32'(out_addr),    32'((6 + k - 1) % 8));
            check_eq("s3.cnt",   32'(pending_cnt), 32'(8 - k));
        end
        step();
        check_eq("s3.end", 32'(out_valid), 32'd0);

        // 6: async reset mid-stream (ptr back to 0 afterwards)
        req = 8'hFF;
        step();
        req = 8'h00;
        step();
        check_eq("s6.addr6", 32'(out_addr), 32'd6);
        step();
        check_eq("s6.addr7", 32'(out_addr), 32'd7);
        #2 reset = 1'b1;
        #1;
        check_idle("s6.async");
        check_eq("s6.addr", 32'(out_addr), 32'd0);
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("s6.post");
        end

        // 4: backpressure with bits 0 and 7, ptr=0
        out_ready = 1'b0;
        req = 8'h81;
        step();
        check_eq("s4.pend", 32'(pending), 32'h81);
        req = 8'h00;
        step();
        check_eq("s4.valid", 32'(out_valid), 32'd1);
        check_eq("s4.addr",  32'(out_addr),  32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("s4.hvalid", 32'(out_valid), 32'd1);
            check_eq("s4.haddr",  32'(out_addr),  32'd0);
            check_eq("s4.hpend",  32'(pending),   32'h80);
        end
        out_ready = 1'b1;
        step();
        check_eq("s4.addr7", 32'(out_addr),  32'd7);
        check_eq("s4.v7",    32'(out_valid), 32'd1);
        step();
        check_eq("s4.end",   32'(out_valid), 32'd0);

        // 5a: merge while bit 3 pending and slot held (ptr=0)
        out_ready = 1'b0;
        req = 8'h0C;
        step();
        check_eq("s5.pend", 32'(pending), 32'h0C);
        req = 8'h00;
        step();
        check_eq("s5.addr2", 32'(out_addr),    32'd2);
        check_eq("s5.cnt1",  32'(pending_cnt), 32'd1);
        req = 8'h08;
        step();
        check_eq("s5.merged", 32'(merged),      32'd1);
        check_eq("s5.mcnt",   32'(pending_cnt), 32'd1);
        check_eq("s5.mpend",  32'(pending),     32'h08);
        check_eq("s5.hold",   32'(out_addr),    32'd2);
        req = 8'h00;
        step();
        check_eq("s5.mpulse", 32'(merged),      32'd0);
        check_eq("s5.cnt",    32'(pending_cnt), 32'd1);

        // 5b: set wins on the load edge of address 3
        out_ready = 1'b1;
        req = 8'h08;
        step();
        check_eq("s5.addr3",  32'(out_addr), 32'd3);
        check_eq("s5.swpend", 32'(pending),  32'h08);
        check_eq("s5.swmrg",  32'(merged),   32'd0);
        req = 8'h00;
        step();
        check_eq("s5.again",  32'(out_addr),  32'd3);
        check_eq("s5.againv", 32'(out_valid), 32'd1);
        check_eq("s5.empty",  32'(pending),   32'h00);
        step();
        check_eq("s5.end",    32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
